// File: rtl/axi_rd_arb.sv
// rtl/axi_rd_arb.sv - round-robin sharing of one AXI read port among NUM_REQ requesters
// Winner index rides in the upper ARID bits; R beats are steered back by those same bits.
module axi_rd_arb #(
    parameter int NUM_REQ    = 4,
    parameter int IDX_W      = 2,
    parameter int ID_W       = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 8,
    parameter int SIZE_W     = 3,
    parameter int BURST_W    = 2,
    parameter int RESP_W     = 2,
    parameter int MAX_OUTSTD = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,

    input  logic [NUM_REQ*ID_W-1:0]      s_arid,
    input  logic [NUM_REQ*ADDR_W-1:0]    s_araddr,
    input  logic [NUM_REQ*LEN_W-1:0]     s_arlen,
    input  logic [NUM_REQ*SIZE_W-1:0]    s_arsize,
    input  logic [NUM_REQ*BURST_W-1:0]   s_arburst,
    input  logic [NUM_REQ-1:0]           s_arvalid,
    output logic [NUM_REQ-1:0]           s_arready,

    output logic [ID_W-1:0]              s_rid,
    output logic [DATA_W-1:0]            s_rdata,
    output logic [RESP_W-1:0]            s_rresp,
    output logic                         s_rlast,
    output logic [NUM_REQ-1:0]           s_rvalid,
    input  logic [NUM_REQ-1:0]           s_rready,

    output logic [IDX_W+ID_W-1:0]        m_arid,
    output logic [ADDR_W-1:0]            m_araddr,
    output logic [LEN_W-1:0]             m_arlen,
    output logic [SIZE_W-1:0]            m_arsize,
    output logic [BURST_W-1:0]           m_arburst,
    output logic                         m_arvalid,
    input  logic                         m_arready,

    input  logic [IDX_W+ID_W-1:0]        m_rid,
    input  logic [DATA_W-1:0]            m_rdata,
    input  logic [RESP_W-1:0]            m_rresp,
    input  logic                         m_rlast,
    input  logic                         m_rvalid,
    output logic                         m_rready,

    output logic                         rd_route_err
);

    localparam int CNT_W = $clog2(MAX_OUTSTD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTD);
    localparam logic [IDX_W:0]   NREQ_X  = (IDX_W+1)'(NUM_REQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   rr_last;
    logic [IDX_W-1:0]   next_idx;
    logic               next_found;
    logic [IDX_W:0]     scan_pos;
    logic [NUM_REQ-1:0] eligible;
    logic [CNT_W-1:0]   cnt [NUM_REQ];
    logic [NUM_REQ-1:0] cnt_inc;
    logic [NUM_REQ-1:0] cnt_dec;

    logic [IDX_W-1:0]   r_idx;
    logic               r_idx_ok;
    logic               r_last_hs;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = s_arvalid[i] && (cnt[i] < CNT_MAX);
        end
    end

    // Scan rr_last+1, rr_last+2, ... wrapping at NUM_REQ; first eligible wins.
    always_comb begin
        next_found = 1'b0;
        next_idx   = '0;
        scan_pos   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_pos = {1'b0, rr_last} + (IDX_W+1)'(k);
            if (scan_pos >= NREQ_X) begin
                scan_pos = scan_pos - NREQ_X;
            end
            if (!next_found && eligible[scan_pos[IDX_W-1:0]]) begin
                next_found = 1'b1;
                next_idx   = scan_pos[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_idx <= '0;
            rr_last   <= IDX_W'(NUM_REQ - 1);
            m_arvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (next_found) begin
                        grant_idx <= next_idx;
                        state     <= GRANT;
                        m_arvalid <= 1'b1;
                    end
                end
                GRANT: begin
                    if (m_arready) begin
                        rr_last   <= grant_idx;
                        state     <= IDLE;
                        m_arvalid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    m_arvalid <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        m_arid    = '0;
        m_araddr  = '0;
        m_arlen   = '0;
        m_arsize  = '0;
        m_arburst = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                m_arid    = {grant_idx, s_arid[i*ID_W +: ID_W]};
                m_araddr  = s_araddr[i*ADDR_W +: ADDR_W];
                m_arlen   = s_arlen[i*LEN_W +: LEN_W];
                m_arsize  = s_arsize[i*SIZE_W +: SIZE_W];
                m_arburst = s_arburst[i*BURST_W +: BURST_W];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            s_arready[i] = m_arvalid && m_arready && (grant_idx == IDX_W'(i));
        end
    end

    assign r_idx    = m_rid[IDX_W+ID_W-1:ID_W];
    assign r_idx_ok = ({1'b0, r_idx} < NREQ_X);
    assign s_rid    = m_rid[ID_W-1:0];
    assign s_rdata  = m_rdata;
    assign s_rresp  = m_rresp;
    assign s_rlast  = m_rlast;

    // Beats carrying an index with no requester behind it are sunk (ready=1).
    always_comb begin
        m_rready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            s_rvalid[i] = m_rvalid && (r_idx == IDX_W'(i));
            if (r_idx == IDX_W'(i)) begin
                m_rready = s_rready[i];
            end
        end
    end

    assign r_last_hs = m_rvalid && m_rready && m_rlast && r_idx_ok;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_inc[i] = m_arvalid && m_arready && (grant_idx == IDX_W'(i));
            cnt_dec[i] = r_last_hs && (r_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (cnt_inc[i] && !cnt_dec[i]) begin
                    if (cnt[i] != CNT_MAX) begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else if (cnt_dec[i] && !cnt_inc[i]) begin
                    if (cnt[i] != '0) begin
                        cnt[i] <= cnt[i] - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_route_err <= 1'b0;
        end else begin
            rd_route_err <= m_rvalid && !r_idx_ok;
        end
    end

endmodule

// File: doc/axi_rd_arb.md
Name: axi_rd_arb

Overview:
- Shares one AXI master read port (AR + R channels) among NUM_REQ read requesters.
- AR requests are arbitrated round-robin. The winner's index is prepended to ARID.
- R beats are routed back to the owning requester by the upper ID bits.
- A per-requester outstanding-burst counter throttles AR issue. The block sits between the read requesters and the interconnect/slave-facing read port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- IDX_W, 2, index bits = clog2(NUM_REQ); must satisfy 2^IDX_W >= NUM_REQ
- ID_W, 4, requester-side ID width
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LEN_W, 8, burst length width
- SIZE_W, 3, size width
- BURST_W, 2, burst type width
- RESP_W, 2, response width
- MAX_OUTSTD, 4, max outstanding bursts per requester (1..15)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- s_arid  in  NUM_REQ*ID_W  per-requester ARID, requester i at slice [i*ID_W +: ID_W]; all s_* buses packed the same way
- s_araddr  in  NUM_REQ*ADDR_W  ARADDR
- s_arlen  in  NUM_REQ*LEN_W  ARLEN
- s_arsize  in  NUM_REQ*SIZE_W  ARSIZE
- s_arburst  in  NUM_REQ*BURST_W  ARBURST
- s_arvalid  in  NUM_REQ  ARVALID
- s_arready  out  NUM_REQ  ARREADY
- s_rid  out  ID_W  RID (lower ID_W bits of m_rid, broadcast)
- s_rdata  out  DATA_W  RDATA (broadcast)
- s_rresp  out  RESP_W  RRESP (broadcast)
- s_rlast  out  1  RLAST (broadcast)
- s_rvalid  out  NUM_REQ  RVALID, one-hot to owner
- s_rready  in  NUM_REQ  RREADY
- m_arid  out  IDX_W+ID_W  {grant_idx, s_arid[grant]}
- m_araddr / m_arlen / m_arsize / m_arburst  out  ADDR_W / LEN_W / SIZE_W / BURST_W  muxed payload of granted requester
- m_arvalid  out  1  ARVALID
- m_arready  in  1  ARREADY
- m_rid  in  IDX_W+ID_W  RID
- m_rdata  in  DATA_W  RDATA
- m_rresp  in  RESP_W  RRESP
- m_rlast  in  1  RLAST
- m_rvalid  in  1  RVALID
- m_rready  out  1  RREADY
- rd_route_err  out  1  one-cycle pulse on R handshake whose index >= NUM_REQ

Behaviour:
- Single clock clk. Reset rst_n is synchronous, active-low.
- Reset clears:
  - state=IDLE; grant_idx=0; rr_last=NUM_REQ-1, so requester 0 has first priority.
  - All outstanding counters=0; rd_route_err=0.
  - Therefore m_arvalid=0, s_arready=0, s_rvalid=0.
- Reset asserted mid-burst abandons all tracking. The bench must not drive R beats for pre-reset bursts.
- Eligibility: eligible[i] = s_arvalid[i] & (cnt[i] < MAX_OUTSTD).
- AR FSM, two states:
  - IDLE: if any requester is eligible, register grant_idx = first eligible index scanning rr_last+1, rr_last+2, ... modulo NUM_REQ, then go to GRANT. Otherwise stay in IDLE.
  - GRANT:
    - m_arvalid=1. m_ar* and m_arid are combinationally muxed from grant_idx.
    - s_arready[grant_idx]=m_arready; all other s_arready bits are 0.
    - On m_arvalid & m_arready: rr_last <= grant_idx, go to IDLE.
    - Otherwise hold. The grant is locked until the handshake; requesters must hold valid and payload stable per AXI.
- AR latency: s_arvalid rising to m_arvalid is 1 cycle. Back-to-back grants have a 1-cycle IDLE bubble, giving AR throughput of at most 1 per 2 cycles.
- m_arvalid is deasserted in IDLE. It never toggles while in GRANT.
- R routing is combinational, with no added latency:
  - idx = m_rid[IDX_W+ID_W-1 : ID_W].
  - If idx < NUM_REQ: s_rvalid = m_rvalid << idx; m_rready = s_rready[idx].
  - If idx >= NUM_REQ: all s_rvalid=0; m_rready=1 (beat sunk); rd_route_err pulses for 1 cycle after each such handshake.
- Outstanding counters, width clog2(MAX_OUTSTD+1):
  - cnt[i] increments on AR handshake with grant_idx==i.
  - cnt[i] decrements on R handshake with m_rlast & idx==i.
  - Both in the same cycle: unchanged.
  - Never wraps. Decrement at 0 holds at 0 (protocol error, not flagged).
- A requester at cnt==MAX_OUTSTD is skipped by arbitration; the others proceed.
- R beats of different IDs may interleave. Routing is per beat.

Test Plan:
- Reset, then requester 1 alone issues araddr=0x10, arlen=3, arid=5 with m_arready=1 → m_arvalid rises 1 cycle after s_arvalid; m_arid={2'd1,4'd5}; s_arready[1] pulses once; cnt[1]=1; 4 R beats with m_rid=0x15 assert only s_rvalid[1]; cnt[1]=0 after the rlast handshake.
- All 4 requesters valid continuously, m_arready=1, arlen=0, R returned immediately → grant order 0,1,2,3,0,1; one AR handshake every 2 cycles.
- Requester 2 with m_arready held low for 5 cycles → m_arvalid and m_arid stay stable; requester 3's valid is not granted until requester 2's handshake.
- MAX_OUTSTD=4, requester 0 issues 4 ARs with no R returned → fifth request from requester 0 is blocked; requester 1 is still granted; one rlast for requester 0 re-enables it the next cycle.
- AR handshake and rlast handshake for the same requester in the same cycle → cnt unchanged (stays 2).
- m_rid index=3 with NUM_REQ=3 → m_rready=1, no s_rvalid asserted, rd_route_err pulses one cycle.
- rst_n driven low for 1 clk while in GRANT with cnt[0]=2 → after reset: m_arvalid=0, all counters=0, requester 0 has priority.
